timer_contagem: RTL and testbench

- Consumer end of the keypad-entry interface (D, loadn, pgt_1Hz) in the microwave timer datapath.
- Captures keyed BCD digits into a 4-digit MM:SS register by shifting each new digit in from the right.
- Counts the register down once per 1 Hz tick while enabled.
- Reports zero, and pulses done when a countdown reaches 00:00.

---
 rtl/timer_contagem.sv | 155 +++++++++++++++
 tb/tb_timer_contagem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_contagem.sv
// -----------------------------------------------------------------------------
// timer_contagem
//
// Microwave timer countdown register. Keyed BCD digits are shifted into a
// 4-digit MM:SS register from the right. While enabled, the register counts
// down one second per 1 Hz tick. A one-cycle done pulse marks a countdown that
// arrives at 00:00.
//
// Ports:
//   clk100      in   system clock, all state changes on its rising edge
//   clearn      in   asynchronous active-low reset
//   D[3:0]      in   BCD digit from the keypad encoder, valid while loadn=0
//   loadn       in   active-low digit strobe, one clk100 cycle per keypress
//   pgt_1Hz     in   single-cycle pulse once per second, synchronous to clk100
//   enablen     in   active-low count enable (0 = running, 1 = entry/paused)
//   sec_ones    out  BCD seconds units
//   sec_tens    out  BCD seconds tens
//   min_ones    out  BCD minutes units
//   min_tens    out  BCD minutes tens
//   zero        out  1 when all four digits are 0 (combinational)
//   done        out  registered one-cycle pulse on countdown arrival at 00:00
//   o_dbg_state out  current FSM state (0 = ENTRY, 1 = RUN)
//
// Keypad handshake: there is no ready/back-pressure. A digit transfer happens
// on every rising clk100 edge where loadn=0, the FSM is in ENTRY and
// D <= DIGIT_MAX. A strobe that does not meet those conditions is dropped.
// -----------------------------------------------------------------------------
module timer_contagem #(
   parameter int unsigned SEC_TENS_MAX = 5,
   parameter int unsigned DIGIT_MAX    = 9
) (
   input  logic       clk100,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       enablen,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       zero,
   output logic       done,
   output logic       o_dbg_state
);

   localparam logic [3:0] L_SEC_TENS_MAX = 4'(SEC_TENS_MAX);
   localparam logic [3:0] L_DIGIT_MAX    = 4'(DIGIT_MAX);

   typedef enum logic {
      ENTRY = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_sec_ones;
   logic [3:0] r_sec_tens;
   logic [3:0] r_min_ones;
   logic [3:0] r_min_tens;
   logic       r_done;

   logic       w_zero;
   logic       w_load_ok;
   logic [3:0] w_dec_sec_ones;
   logic [3:0] w_dec_sec_tens;
   logic [3:0] w_dec_min_ones;
   logic [3:0] w_dec_min_tens;

   assign w_zero = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) &&
                   (r_min_ones == 4'd0) && (r_min_tens == 4'd0);

   assign w_load_ok = !loadn && (D <= L_DIGIT_MAX);

   // One-second decrement with borrow chain. At 00:00 the value holds, so the
   // register never wraps below zero.
   always_comb begin
      w_dec_sec_ones = r_sec_ones;
      w_dec_sec_tens = r_sec_tens;
      w_dec_min_ones = r_min_ones;
      w_dec_min_tens = r_min_tens;
      if (r_sec_ones != 4'd0) begin
         w_dec_sec_ones = r_sec_ones - 4'd1;
      end else if (r_sec_tens != 4'd0) begin
         w_dec_sec_tens = r_sec_tens - 4'd1;
         w_dec_sec_ones = L_DIGIT_MAX;
      end else if (r_min_ones != 4'd0) begin
         w_dec_min_ones = r_min_ones - 4'd1;
         w_dec_sec_tens = L_SEC_TENS_MAX;
         w_dec_sec_ones = L_DIGIT_MAX;
      end else if (r_min_tens != 4'd0) begin
         w_dec_min_tens = r_min_tens - 4'd1;
         w_dec_min_ones = L_DIGIT_MAX;
         w_dec_sec_tens = L_SEC_TENS_MAX;
         w_dec_sec_ones = L_DIGIT_MAX;
      end
   end

   always_ff @(posedge clk100 or negedge clearn) begin
      if (!clearn) begin
         r_state    <= ENTRY;
         r_sec_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_min_tens <= 4'd0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ENTRY: begin
               // Shift the new digit in from the right; old min_tens drops out.
               if (w_load_ok) begin
                  r_min_tens <= r_min_ones;
                  r_min_ones <= r_sec_tens;
                  r_sec_tens <= r_sec_ones;
                  r_sec_ones <= D;
               end
               // The start decision uses the value before any load on this
               // edge, and a tick on this edge is not counted.
               if (!enablen && !w_zero) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_zero) begin
                  // Only a decrement can bring RUN to 00:00, so this is always
                  // a countdown arrival: finish and pulse done.
                  r_state <= ENTRY;
                  r_done  <= 1'b1;
               end else begin
                  // A tick on the same edge that enablen rises still counts.
                  if (pgt_1Hz) begin
                     r_sec_ones <= w_dec_sec_ones;
                     r_sec_tens <= w_dec_sec_tens;
                     r_min_ones <= w_dec_min_ones;
                     r_min_tens <= w_dec_min_tens;
                  end
                  if (enablen) begin
                     r_state <= ENTRY;
                  end
               end
            end
            default: r_state <= ENTRY;
         endcase
      end
   end

   assign sec_ones    = r_sec_ones;
   assign sec_tens    = r_sec_tens;
   assign min_ones    = r_min_ones;
   assign min_tens    = r_min_tens;
   assign zero        = w_zero;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_contagem.sv
// -----------------------------------------------------------------------------
// tb_timer_contagem
//
// Directed bench for timer_contagem. Inputs change 1 ns after a rising edge,
// outputs are checked 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_timer_contagem;

   logic       clk100;
   logic       clearn;
   logic [3:0] D;
   logic       loadn;
   logic       pgt_1Hz;
   logic       enablen;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       zero;
   logic       done;
   logic       o_dbg_state;

   int n_cmp;
   int n_err;

   localparam logic ST_ENTRY = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   timer_contagem dut (
      .clk100      (clk100),
      .clearn      (clearn),
      .D           (D),
      .loadn       (loadn),
      .pgt_1Hz     (pgt_1Hz),
      .enablen     (enablen),
      .sec_ones    (sec_ones),
      .sec_tens    (sec_tens),
      .min_ones    (min_ones),
      .min_tens    (min_tens),
      .zero        (zero),
      .done        (done),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset
   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   // driver tasks
   task automatic tick();
      @(posedge clk100);
      #1;
   endtask

   task automatic do_reset();
      clearn = 1'b0;
      tick();
      clearn = 1'b1;
   endtask

   task automatic strobe(input logic [3:0] d);
      loadn = 1'b0;
      D     = d;
      tick();
      loadn = 1'b1;
      D     = 4'd0;
   endtask

   task automatic pulse();
      pgt_1Hz = 1'b1;
      tick();
      pgt_1Hz = 1'b0;
   endtask

   // checkers
   task automatic chk_digits(input string tag, input logic [15:0] exp);
      logic [15:0] got;
      got = {min_tens, min_ones, sec_tens, sec_ones};
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s digits got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      clearn  = 1'b0;
      D       = 4'd0;
      loadn   = 1'b1;
      pgt_1Hz = 1'b0;
      enablen = 1'b1;

      // reset state
      tick();
      tick();
      chk_digits("reset_digits", 16'h0000);
      chk_bit("reset_zero", zero, 1'b1);
      chk_bit("reset_done", done, 1'b0);
      chk_bit("reset_state", o_dbg_state, ST_ENTRY);
      clearn = 1'b1;
      tick();

      // entry shifting
      strobe(4'd1);
      chk_digits("entry_1", 16'h0001);
      strobe(4'd2);
      strobe(4'd3);
      strobe(4'd4);
      chk_digits("entry_1234", 16'h1234);
      chk_bit("entry_zero", zero, 1'b0);
      strobe(4'd12);
      chk_digits("entry_illegal", 16'h1234);
      strobe(4'd5);
      chk_digits("entry_2345", 16'h2345);

      // async reset mid-count at 01:30
      do_reset();
      strobe(4'd1);
      strobe(4'd3);
      strobe(4'd0);
      chk_digits("load_0130", 16'h0130);
      enablen = 1'b0;
      tick();
      chk_bit("run_0130_state", o_dbg_state, ST_RUN);
      pulse();
      chk_digits("run_0129", 16'h0129);
      #2 clearn = 1'b0;
      #1;
      chk_digits("async_rst_digits", 16'h0000);
      chk_bit("async_rst_zero", zero, 1'b1);
      chk_bit("async_rst_done", done, 1'b0);
      chk_bit("async_rst_state", o_dbg_state, ST_ENTRY);
      enablen = 1'b1;
      tick();
      clearn = 1'b1;
      tick();

      // borrow chain from 10:00
      strobe(4'd1);
      strobe(4'd0);
      strobe(4'd0);
      strobe(4'd0);
      chk_digits("load_1000", 16'h1000);
      enablen = 1'b0;
      pgt_1Hz = 1'b1;      // tick on the start edge is not counted
      tick();
      pgt_1Hz = 1'b0;
      chk_digits("start_tick_ignored", 16'h1000);
      chk_bit("borrow_state_run", o_dbg_state, ST_RUN);
      pulse();
      chk_digits("borrow_0959", 16'h0959);
      pulse();
      chk_digits("borrow_0958", 16'h0958);
      enablen = 1'b1;
      tick();
      chk_bit("borrow_paused", o_dbg_state, ST_ENTRY);
      chk_digits("borrow_hold", 16'h0958);
      pulse();
      chk_digits("borrow_pause_hold", 16'h0958);

      // 0:99 counts down to 00:00
      do_reset();
      strobe(4'd9);
      strobe(4'd9);
      chk_digits("load_0099", 16'h0099);
      enablen = 1'b0;
      tick();
      pulse();
      chk_digits("ns_0098", 16'h0098);
      pulse();
      chk_digits("ns_0097", 16'h0097);
      for (int i = 0; i < 87; i++) pulse();
      chk_digits("ns_0010", 16'h0010);
      pulse();
      chk_digits("ns_0009", 16'h0009);
      for (int i = 0; i < 8; i++) pulse();
      chk_digits("ns_0001", 16'h0001);
      chk_bit("ns_done_pre", done, 1'b0);
      pulse();
      chk_digits("ns_0000", 16'h0000);
      chk_bit("ns_zero", zero, 1'b1);
      chk_bit("ns_done_not_yet", done, 1'b0);
      tick();
      chk_bit("ns_done_pulse", done, 1'b1);
      chk_bit("ns_state_entry", o_dbg_state, ST_ENTRY);
      tick();
      chk_bit("ns_done_width", done, 1'b0);
      pulse();
      chk_digits("ns_no_wrap", 16'h0000);
      chk_bit("ns_done_after_pgt", done, 1'b0);
      tick();
      chk_bit("ns_done_stays0", done, 1'b0);
      chk_bit("ns_state_stays", o_dbg_state, ST_ENTRY);

      // pause / resume at 00:05
      enablen = 1'b1;
      do_reset();
      strobe(4'd5);
      enablen = 1'b0;
      tick();
      chk_bit("pr_run", o_dbg_state, ST_RUN);
      strobe(4'd7);        // ignored in RUN
      chk_digits("pr_load_ignored", 16'h0005);
      loadn   = 1'b0;      // load and tick together in RUN: tick wins
      D       = 4'd7;
      pgt_1Hz = 1'b1;
      tick();
      loadn   = 1'b1;
      pgt_1Hz = 1'b0;
      chk_digits("pr_pgt_wins", 16'h0004);
      enablen = 1'b1;
      tick();
      chk_bit("pr_paused", o_dbg_state, ST_ENTRY);
      pulse();
      pulse();
      pulse();
      chk_digits("pr_hold", 16'h0004);
      chk_bit("pr_done_paused", done, 1'b0);
      enablen = 1'b0;
      tick();
      chk_bit("pr_resumed", o_dbg_state, ST_RUN);
      pulse();
      chk_digits("pr_0003", 16'h0003);
      enablen = 1'b1;      // tick on the pausing edge still counts
      pgt_1Hz = 1'b1;
      tick();
      pgt_1Hz = 1'b0;
      chk_digits("pr_pause_edge_tick", 16'h0002);
      chk_bit("pr_pause_edge_state", o_dbg_state, ST_ENTRY);
      loadn   = 1'b0;      // load and tick together in ENTRY: load wins
      D       = 4'd1;
      pgt_1Hz = 1'b1;
      tick();
      loadn   = 1'b1;
      pgt_1Hz = 1'b0;
      chk_digits("entry_load_wins", 16'h0021);

      // empty start
      do_reset();
      enablen = 1'b0;
      pulse();
      chk_bit("empty_state", o_dbg_state, ST_ENTRY);
      chk_bit("empty_done", done, 1'b0);
      pulse();
      tick();
      chk_bit("empty_state2", o_dbg_state, ST_ENTRY);
      chk_bit("empty_done2", done, 1'b0);
      chk_digits("empty_digits", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
